// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings, FSM states and the decoder-facing funct constants.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  localparam logic [5:0] OPC_SPECIAL = 6'd0;
  localparam logic [5:0] FN_MTHI     = 6'd17;
  localparam logic [5:0] FN_MTLO     = 6'd19;
  localparam logic [5:0] FN_MULT     = 6'd24;
  localparam logic [5:0] FN_MULTU    = 6'd25;
  localparam logic [5:0] FN_DIV      = 6'd26;
  localparam logic [5:0] FN_DIVU     = 6'd27;

  function automatic mdu_op_e funct_to_op(
    input logic [5:0] fn
  );
    mdu_op_e r;
    r = MDU_MULTU;
    unique case (1'b1)
      fn == FN_MULT:  r = MDU_MULT;
      fn == FN_DIV:   r = MDU_DIV;
      fn == FN_DIVU:  r = MDU_DIVU;
      default:        r = MDU_MULTU;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the core and the MDU.
// The core drives requests; the MDU returns status and HI/LO.
interface mdu_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        output hi_we, lo_we, wdata,
        input  busy, done, div_by_zero,
        input  hi, lo
    );

    modport slave (
        input  start, op, a, b,
        input  hi_we, lo_we, wdata,
        output busy, done, div_by_zero,
        output hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// One accumulator serves shift-add multiply and restoring divide.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic clk,
    input logic rst_n,
    mdu_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mdu_state_e         state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               dz;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               done_r, dbz_r;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     msum, rsh, diff;
    logic [2*WIDTH-1:0] acc_step, prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    function automatic logic [WIDTH-1:0] neg_w(
        input logic [WIDTH-1:0] v,
        input logic             en
    );
        return en ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_d(
        input logic [2*WIDTH-1:0] v,
        input logic               en
    );
        return en ? (~v + 1'b1) : v;
    endfunction

    // Signed ops run on magnitudes; signs are restored in FIX
    assign a_neg = bus.op[0] & bus.a[WIDTH-1];
    assign b_neg = bus.op[0] & bus.b[WIDTH-1];
    assign mag_a = neg_w(bus.a, a_neg);
    assign mag_b = neg_w(bus.b, b_neg);

    always_comb begin
        msum = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (acc[0] ? {1'b0, opb} : '0);
        rsh  = acc[2*WIDTH-1:WIDTH-1];
        diff = rsh - {1'b0, opb};
        if (is_div) begin
            if (diff[WIDTH])
                acc_step = {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {msum, acc[WIDTH-1:1]};
        end
    end

    // Zero divisor leaves the dividend magnitude as remainder,
    // so sign correction returns the original dividend in HI
    always_comb begin
        prod   = neg_d(acc, neg_res);
        quo    = neg_w(acc[WIDTH-1:0], neg_res);
        rem    = neg_w(acc[2*WIDTH-1:WIDTH], neg_rem);
        fin_hi = prod[2*WIDTH-1:WIDTH];
        fin_lo = prod[WIDTH-1:0];
        if (is_div) begin
            fin_hi = rem;
            fin_lo = dz ? '1 : quo;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.start) state_n = CALC;
            CALC:    if (cnt == LAST) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            opb     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            done_r  <= 1'b0;
            dbz_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.hi_we) hi_r <= bus.wdata;
                    if (bus.lo_we) lo_r <= bus.wdata;
                    if (bus.start) begin
                        is_div  <= bus.op[1];
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= bus.op[1] & a_neg;
                        dz      <= bus.op[1] & (bus.b == '0);
                        acc     <= {{WIDTH{1'b0}}, mag_a};
                        opb     <= mag_b;
                        cnt     <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    hi_r   <= fin_hi;
                    lo_r   <= fin_lo;
                    done_r <= 1'b1;
                    dbz_r  <= dz;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against an arithmetic model.
// Directed cases plus randomized operations with corner operands.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    mdu_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(
        input  logic [1:0]   op,
        input  logic [W-1:0] a,
        input  logic [W-1:0] b,
        output logic [W-1:0] eh,
        output logic [W-1:0] el,
        output logic         ed
    );
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ed = 1'b0;
        case (op)
            MDU_MULTU: begin
                p  = {32'h0, a} * {32'h0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            MDU_MULT: begin
                p  = sa * sb;
                eh = p[63:32];
                el = p[31:0];
            end
            default: begin
                if (b == 0) begin
                    ed = 1'b1;
                    el = '1;
                    eh = a;
                end else if (op == MDU_DIVU) begin
                    el = a / b;
                    eh = a % b;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    p  = q;
                    el = p[31:0];
                    p  = r;
                    eh = p[31:0];
                end
            end
        endcase
    endtask

    // Called #1 after a rising edge with the unit idle
    task automatic run_op(
        input logic [1:0]   op,
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input bit           disturb,
        input bit           tail
    );
        logic [W-1:0] eh, el;
        logic         ed;
        int           lat;
        bit           busy_ok;
        model(op, a, b, eh, el, ed);
        check("idle_before", bus.busy, 1'b0);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        if (bus.hi_we) check("we_with_start", bus.hi, bus.wdata);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        lat     = 0;
        busy_ok = 1'b1;
        while (!bus.done && lat < LAT + 8) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (disturb && lat == 5) begin
                bus.start = 1'b1;
                bus.op    = ~op;
                bus.a     = ~a;
                bus.b     = b + 1;
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
                bus.wdata = $urandom;
            end else if (disturb && lat == 6) begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
                bus.lo_we = 1'b0;
            end
        end
        check("latency", lat, LAT);
        check("busy_hold", busy_ok, 1'b1);
        check("busy_done", bus.busy, 1'b0);
        check("hi", bus.hi, eh);
        check("lo", bus.lo, el);
        check("dbz", bus.div_by_zero, ed);
        if (tail) begin
            @(posedge clk); #1;
            check("done_pulse", bus.done, 1'b0);
            check("no_queue", bus.busy, 1'b0);
            check("hi_hold", bus.hi, eh);
        end
    endtask

    logic [1:0]   r_op;
    logic [W-1:0] r_a, r_b;

    initial begin
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_dbz", bus.div_by_zero, 1'b0);
        check("rst_hi", bus.hi, '0);
        check("rst_lo", bus.lo, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
        run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        run_op(MDU_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op(MDU_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(MDU_DIVU, 32'd5, 32'd0, 1'b0, 1'b0);
        run_op(MDU_DIV, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b1);

        run_op(MDU_MULT, 32'h0123_4567, 32'hFFF8_9ABC, 1'b1, 1'b1);
        run_op(MDU_DIVU, 32'd1000, 32'd33, 1'b0, 1'b0);
        run_op(MDU_DIV, 32'h8765_4321, 32'd12345, 1'b0, 1'b1);

        bus.lo_we = 1'b1;
        bus.wdata = 32'h1234;
        @(posedge clk); #1;
        bus.lo_we = 1'b0;
        check("mtlo_lo", bus.lo, 32'h1234);
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("both_hi", bus.hi, 32'hCAFE_F00D);
        check("both_lo", bus.lo, 32'hCAFE_F00D);

        bus.hi_we = 1'b1;
        bus.wdata = 32'h5555_AAAA;
        run_op(MDU_MULTU, 32'd3, 32'd9, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            if ($urandom_range(0, 7) == 0) r_a = 32'h8000_0000;
            case ($urandom_range(0, 5))
                0:       r_b = '0;
                1:       r_b = '1;
                2:       r_b = $urandom_range(1, 15);
                default: r_b = $urandom;
            endcase
            run_op(r_op, r_a, r_b, 1'b0, (i % 2) == 1);
        end

        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.start = 1'b1;
        bus.op    = MDU_MULT;
        bus.a     = 32'h0000_7777;
        bus.b     = 32'hFFFF_0003;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 1'b0);
        check("arst_done", bus.done, 1'b0);
        check("arst_hi", bus.hi, '0);
        check("arst_lo", bus.lo, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_idle", bus.busy, 1'b0);
        run_op(MDU_DIVU, 32'd100, 32'd7, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
